// File: rtl/serial_adder.sv
// serial_adder: bit-serial WIDTH-bit adder feeding one fullAdder cell LSB first.
// Start captures A/B/Cin; WIDTH shift cycles later Sum/Cout update with a Done pulse.
module fullAdder (
    input  logic A,
    input  logic B,
    input  logic Cin,
    output logic Sum,
    output logic Cout
);
    assign Sum  = A ^ B ^ Cin;
    assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state_q, state_d;
    logic [WIDTH-1:0] ra_q, ra_d, rb_q, rb_d, ps_q, ps_d, sum_q, sum_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             c_q, c_d, cout_q, cout_d, done_q, done_d;
    logic             s_bit, c_out;

    fullAdder u_fa (
        .A   (ra_q[0]),
        .B   (rb_q[0]),
        .Cin (c_q),
        .Sum (s_bit),
        .Cout(c_out)
    );

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        ps_d    = ps_q;
        c_d     = c_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: if (Start) begin
                ra_d    = A;
                rb_d    = B;
                c_d     = Cin;
                cnt_d   = '0;
                state_d = SHIFT;
            end
            SHIFT: begin
                ra_d  = ra_q >> 1;
                rb_d  = rb_q >> 1;
                ps_d  = {s_bit, ps_q[WIDTH-1:1]};
                c_d   = c_out;
                cnt_d = cnt_q + CW'(1);
                // Last bit: the sum bit just produced completes the result
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = {s_bit, ps_q[WIDTH-1:1]};
                    cout_d  = c_out;
                    done_d  = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            ps_q    <= '0;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            ps_q    <= ps_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
        end
    end

    assign Busy = (state_q != IDLE);
    assign Done = done_q;
    assign Sum  = sum_q;
    assign Cout = cout_q;
endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder: scoreboard bench for serial_adder at WIDTH=8 and WIDTH=4.
module tb_serial_adder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
    logic [7:0] a8 = '0, b8 = '0, sum8;
    logic       start4 = 1'b0, cin4 = 1'b0, busy4, done4, cout4;
    logic [3:0] a4 = '0, b4 = '0, sum4;
    int         cyc = 0, pass_cnt = 0, chk_cnt = 0;
    logic [8:0] q8[$];
    logic [4:0] q4[$];
    int         d8[$];
    int         last4 = -1, n4 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .Start(start8), .A(a8), .B(b8), .Cin(cin8),
        .Busy(busy8), .Done(done8), .Sum(sum8), .Cout(cout8)
    );
    serial_adder #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .Start(start4), .A(a4), .B(b4), .Cin(cin4),
        .Busy(busy4), .Done(done4), .Sum(sum4), .Cout(cout4)
    );

    // Scoreboards: every Done pops the oldest expected {Cout,Sum}
    always @(negedge clk) begin
        if (done8) begin
            logic [8:0] e;
            chk_cnt++;
            d8.push_back(cyc);
            if (q8.size() == 0) $display("FAIL sb8: unexpected Done, got %h expected none", {cout8, sum8});
            else begin
                e = q8.pop_front();
                if ({cout8, sum8} !== e) $display("FAIL sb8: got %h expected %h", {cout8, sum8}, e);
                else pass_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (done4) begin
            logic [4:0] e;
            chk_cnt++;
            n4++;
            if (q4.size() == 0) $display("FAIL sb4: unexpected Done, got %h expected none", {cout4, sum4});
            else begin
                e = q4.pop_front();
                if ({cout4, sum4} !== e) $display("FAIL sb4: got %h expected %h", {cout4, sum4}, e);
                else pass_cnt++;
            end
            if (last4 >= 0) begin
                chk_cnt++;
                if (cyc - last4 !== 6) $display("FAIL spacing4: got %0d expected 6", cyc - last4);
                else pass_cnt++;
            end
            last4 = cyc;
        end
    end

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk_cnt++; if (busy8 !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy8); else pass_cnt++;
        chk_cnt++; if (done8 !== 1'b0) $display("FAIL reset_done: got %b expected 0", done8); else pass_cnt++;
        chk_cnt++; if (sum8 !== 8'h00) $display("FAIL reset_sum: got %h expected 00", sum8); else pass_cnt++;
        chk_cnt++; if (cout8 !== 1'b0) $display("FAIL reset_cout: got %b expected 0", cout8); else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int e0, nb = 0, nd = 0, dc = -1;
        start8 = 1'b1; a8 = 8'h5A; b8 = 8'h3C; cin8 = 1'b0;
        q8.push_back(9'h096);
        @(posedge clk); #1;
        e0 = cyc;
        start8 = 1'b0; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (busy8) nb++;
            if (done8) begin nd++; dc = cyc; end
        end
        chk_cnt++; if (nd !== 1) $display("FAIL basic_done_count: got %0d expected 1", nd); else pass_cnt++;
        chk_cnt++; if (dc !== e0 + 8) $display("FAIL basic_done_edge: got %0d expected %0d", dc - e0, 8); else pass_cnt++;
        chk_cnt++; if (nb !== 9) $display("FAIL basic_busy_cycles: got %0d expected 9", nb); else pass_cnt++;
        chk_cnt++; if (sum8 !== 8'h96) $display("FAIL basic_sum_hold: got %h expected 96", sum8); else pass_cnt++;
    endtask

    task automatic test_carry();
        logic [16:0] tbl[3] = '{{8'hFF, 8'h01, 1'b0}, {8'hFF, 8'hFF, 1'b1}, {8'h80, 8'h80, 1'b0}};
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            {a8, b8, cin8} = tbl[k];
            start8 = 1'b1;
            q8.push_back({1'b0, tbl[k][16:9]} + {1'b0, tbl[k][8:1]} + 9'(tbl[k][0]));
            @(posedge clk); #1;
            start8 = 1'b0;
            for (int i = 0; i < 30 && q8.size() != 0; i++) @(negedge clk);
            chk_cnt++; if (q8.size() !== 0) $display("FAIL carry_timeout: got %0d pending expected 0", q8.size()); else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        d8.delete();
        for (int k = 0; k < 30; k++) begin
            a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom_range(0, 1));
            start8 = 1'b1;
            if (k % 10 == 0) q8.push_back({1'b0, a8} + {1'b0, b8} + 9'(cin8));
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk_cnt++; if (d8.size() !== 3) $display("FAIL b2b_done_count: got %0d expected 3", d8.size()); else pass_cnt++;
        for (int i = 1; i < d8.size(); i++) begin
            chk_cnt++;
            if (d8[i] - d8[i-1] !== 10) $display("FAIL b2b_spacing: got %0d expected 10", d8[i] - d8[i-1]);
            else pass_cnt++;
        end
        chk_cnt++; if (q8.size() !== 0) $display("FAIL b2b_pending: got %0d expected 0", q8.size()); else pass_cnt++;
    endtask

    task automatic test_abort();
        int nd = 0;
        start8 = 1'b1; a8 = 8'h77; b8 = 8'h99; cin8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_cnt++; if (busy8 !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy8); else pass_cnt++;
        chk_cnt++; if (done8 !== 1'b0) $display("FAIL abort_done: got %b expected 0", done8); else pass_cnt++;
        chk_cnt++; if (sum8 !== 8'h00) $display("FAIL abort_sum: got %h expected 00", sum8); else pass_cnt++;
        chk_cnt++; if (cout8 !== 1'b0) $display("FAIL abort_cout: got %b expected 0", cout8); else pass_cnt++;
        repeat (15) begin
            @(negedge clk);
            if (done8) nd++;
        end
        chk_cnt++; if (nd !== 0) $display("FAIL abort_no_done: got %0d expected 0", nd); else pass_cnt++;
        @(posedge clk); #1;
        start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; cin8 = 1'b1;
        q8.push_back(9'h003);
        @(posedge clk); #1;
        start8 = 1'b0;
        for (int i = 0; i < 30 && q8.size() != 0; i++) @(negedge clk);
        chk_cnt++; if (q8.size() !== 0) $display("FAIL abort_fresh_timeout: got %0d pending expected 0", q8.size()); else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_rst_start();
        int nb = 0;
        rst = 1'b1; start8 = 1'b1; a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; start8 = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (busy8) nb++;
        end
        chk_cnt++; if (nb !== 0) $display("FAIL rst_start_busy: got %0d busy cycles expected 0", nb); else pass_cnt++;
    endtask

    task automatic test_exhaustive4();
        for (int i = 0; i < 512; i++) begin
            {cin4, a4, b4} = 9'(i);
            start4 = 1'b1;
            q4.push_back({1'b0, a4} + {1'b0, b4} + 5'(cin4));
            repeat (6) @(posedge clk);
            #1;
        end
        start4 = 1'b0;
        for (int i = 0; i < 20 && q4.size() != 0; i++) @(negedge clk);
        chk_cnt++; if (q4.size() !== 0) $display("FAIL ex4_pending: got %0d expected 0", q4.size()); else pass_cnt++;
        chk_cnt++; if (n4 !== 512) $display("FAIL ex4_done_count: got %0d expected 512", n4); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_back_to_back();
        test_abort();
        test_rst_start();
        test_exhaustive4();
        chk_cnt++; if (q8.size() !== 0) $display("FAIL sb8_drain: got %0d pending expected 0", q8.size()); else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
